shift_seq_ctrl: RTL

Sequencing controller for the bit-serial 32-bit shift datapath. It accepts a shift command (operand, operation, amount), loads the operand into its shift register, and steps it one bit position per clock until the requested amount is reached. It then pulses `done`. It sits between the ALU issue logic and the serial shift register, so the rest of the design never drives shift-enable or load lines directly.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_seq_ctrl_if.sv | 32 +++
 rtl/shift_dp.sv | 55 +++++
 rtl/shift_seq_ctrl.sv | 85 ++++++++
 4 files changed

// File: rtl/shift_pkg.sv
//==============================================================================
// shift_pkg : shared defaults, op encodings and FSM state encoding
// Revision  : 1.0
//==============================================================================
`default_nettype none

package shift_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_SHW   = 5;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
//==============================================================================
// shift_seq_ctrl_if : command/status bundle between issue logic and sequencer
// Revision          : 1.0
//==============================================================================
`default_nettype none

interface shift_seq_ctrl_if #(
   parameter int WIDTH = shift_pkg::DEFAULT_WIDTH,
   parameter int SHW   = shift_pkg::DEFAULT_SHW
);

   logic             start;
   logic [1:0]       op;
   logic [SHW-1:0]   amount;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, amount, data_in,
      input  busy, done, result
   );

   modport slave (
      input  start, op, amount, data_in,
      output busy, done, result
   );

endinterface

`default_nettype wire

// File: rtl/shift_dp.sv
//==============================================================================
// shift_dp : WIDTH-bit serial shift register with per-bit next-value mux
// Revision : 1.0
//==============================================================================
`default_nettype none

module shift_dp
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  wire logic             clock,
   input  wire logic             resetn,
   input  wire logic             load,
   input  wire logic             shift_en,
   input  wire op_t              op,
   input  wire logic [WIDTH-1:0] data_in,
   output logic      [WIDTH-1:0] result
);

   logic [WIDTH-1:0] nxt;
   logic             fill;

   // Bit entering at the MSB for the three right-moving operations
   always_comb begin
      case (op)
         OP_SRA:  fill = result[WIDTH-1];
         OP_ROR:  fill = result[0];
         default: fill = 1'b0;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
         assign nxt[i] = (op == OP_SLL) ? 1'b0 : result[i+1];
      end else if (i == WIDTH - 1) begin : g_msb
         assign nxt[i] = (op == OP_SLL) ? result[i-1] : fill;
      end else begin : g_mid
         assign nxt[i] = (op == OP_SLL) ? result[i-1] : result[i+1];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         result <= '0;
      end else if (load) begin
         result <= data_in;
      end else if (shift_en) begin
         result <= nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
//==============================================================================
// shift_seq_ctrl : sequences a bit-serial shift, one position per clock
// Revision       : 1.0
//==============================================================================
`default_nettype none

module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SHW   = DEFAULT_SHW
) (
   input wire logic         clock,
   input wire logic         resetn,
   shift_seq_ctrl_if.slave  bus
);

   state_t         state;
   state_t         state_nxt;
   logic [SHW-1:0] count;
   op_t            op_q;
   logic           load;
   logic           shift_en;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = (bus.amount == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (count == SHW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // op and amount are captured only on the accepted start edge
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
         op_q  <= OP_SLL;
      end else if (load) begin
         count <= bus.amount;
         op_q  <= op_t'(bus.op);
      end else if (shift_en) begin
         count <= count - SHW'(1);
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);

   shift_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clock    (clock),
      .resetn   (resetn),
      .load     (load),
      .shift_en (shift_en),
      .op       (op_q),
      .data_in  (bus.data_in),
      .result   (bus.result)
   );

endmodule

`default_nettype wire
